// File: rtl/tpg_pkg.sv
// Shared types for the test pattern generator mode controller: field indices,
// controller states and the timing-set record. TPG_MODE_CTRL_BLANK_EN adds the BLANK state.
package tpg_pkg;

  localparam int TPG_H_BITS = 12;
  localparam int TPG_V_BITS = 12;
  localparam int N_FIELDS   = 10;

  localparam logic [3:0] F_HS_START   = 4'd0;
  localparam logic [3:0] F_HS_END     = 4'd1;
  localparam logic [3:0] F_HACT_START = 4'd2;
  localparam logic [3:0] F_HACT_END   = 4'd3;
  localparam logic [3:0] F_H_END      = 4'd4;
  localparam logic [3:0] F_VS_START   = 4'd5;
  localparam logic [3:0] F_VS_END     = 4'd6;
  localparam logic [3:0] F_VACT_START = 4'd7;
  localparam logic [3:0] F_VACT_END   = 4'd8;
  localparam logic [3:0] F_V_END      = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_WAIT_FE = 3'd2,
`ifdef TPG_MODE_CTRL_BLANK_EN
    ST_BLANK   = 3'd4,
`endif
    ST_LOAD    = 3'd3
  } tpgState_t;

  typedef struct packed {
    logic [TPG_H_BITS-1:0] hsStart;
    logic [TPG_H_BITS-1:0] hsEnd;
    logic [TPG_H_BITS-1:0] hactStart;
    logic [TPG_H_BITS-1:0] hactEnd;
    logic [TPG_H_BITS-1:0] hEnd;
    logic [TPG_V_BITS-1:0] vsStart;
    logic [TPG_V_BITS-1:0] vsEnd;
    logic [TPG_V_BITS-1:0] vactStart;
    logic [TPG_V_BITS-1:0] vactEnd;
    logic [TPG_V_BITS-1:0] vEnd;
  } timingSet_t;

  // A mode with zero frame width or height would stall the generator.
  function automatic logic isValidSet(input timingSet_t s);
    return (s.hEnd != {TPG_H_BITS{1'b0}}) && (s.vEnd != {TPG_V_BITS{1'b0}});
  endfunction

endpackage

// File: rtl/tpg_mode_ctrl_if.sv
// Host/config, request handshake and generator-facing signals of the mode controller.
interface tpg_mode_ctrl_if #(
  parameter int H_BITS    = 12,
  parameter int V_BITS    = 12,
  parameter int MODE_BITS = 2
);
  logic                 cfg_wr;
  logic [MODE_BITS-1:0] cfg_idx;
  logic [3:0]           cfg_field;
  logic [15:0]          cfg_data;
  logic                 mode_req;
  logic [MODE_BITS-1:0] mode_sel;
  logic                 stop_req;
  logic                 frame_end;
  logic                 mode_ack;
  logic                 mode_err;
  logic                 tpg_en;
  logic [MODE_BITS-1:0] cur_mode;
  logic [H_BITS-1:0]    tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
  logic [V_BITS-1:0]    tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;

  modport master (
    output cfg_wr, cfg_idx, cfg_field, cfg_data, mode_req, mode_sel, stop_req, frame_end,
    input  mode_ack, mode_err, tpg_en, cur_mode,
    input  tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END,
    input  tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END
  );

  modport slave (
    input  cfg_wr, cfg_idx, cfg_field, cfg_data, mode_req, mode_sel, stop_req, frame_end,
    output mode_ack, mode_err, tpg_en, cur_mode,
    output tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END,
    output tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END
  );
endinterface

// File: rtl/tpg_mode_table.sv
// Shadow store of timing modes: MODES entries of ten fields, written one field at a time,
// read combinationally so a write in the applying cycle lands only after that cycle.
module tpg_mode_table
  import tpg_pkg::*;
#(
  parameter int MODES     = 4,
  parameter int MODE_BITS = $clog2(MODES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wrEn,
  input  logic [MODE_BITS-1:0] wrIdx,
  input  logic [3:0]           wrField,
  input  logic [15:0]          wrData,
  input  logic [MODE_BITS-1:0] rdIdx,
  output timingSet_t           rdSet
);

  timingSet_t modeTable_r [MODES];

  wire unusedDataHi_s = ^wrData[15:TPG_H_BITS];

  // Field write decode; field numbers 10..15 fall through and change nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MODES; i++) begin
        modeTable_r[i] <= {$bits(timingSet_t){1'b0}};
      end
    end else if (wrEn) begin
      case (wrField)
        F_HS_START:   modeTable_r[wrIdx].hsStart   <= wrData[TPG_H_BITS-1:0];
        F_HS_END:     modeTable_r[wrIdx].hsEnd     <= wrData[TPG_H_BITS-1:0];
        F_HACT_START: modeTable_r[wrIdx].hactStart <= wrData[TPG_H_BITS-1:0];
        F_HACT_END:   modeTable_r[wrIdx].hactEnd   <= wrData[TPG_H_BITS-1:0];
        F_H_END:      modeTable_r[wrIdx].hEnd      <= wrData[TPG_H_BITS-1:0];
        F_VS_START:   modeTable_r[wrIdx].vsStart   <= wrData[TPG_V_BITS-1:0];
        F_VS_END:     modeTable_r[wrIdx].vsEnd     <= wrData[TPG_V_BITS-1:0];
        F_VACT_START: modeTable_r[wrIdx].vactStart <= wrData[TPG_V_BITS-1:0];
        F_VACT_END:   modeTable_r[wrIdx].vactEnd   <= wrData[TPG_V_BITS-1:0];
        F_V_END:      modeTable_r[wrIdx].vEnd      <= wrData[TPG_V_BITS-1:0];
        default: begin end
      endcase
    end
  end

  assign rdSet = modeTable_r[rdIdx];

endmodule

// File: rtl/tpg_mode_ctrl.sv
// Applies table modes to the pattern generator timing inputs at frame boundaries.
// TPG_MODE_CTRL_BLANK_EN: hold the generator disabled BLANK_CYC cycles after a live switch.
module tpg_mode_ctrl
  import tpg_pkg::*;
#(
  parameter int H_BITS    = 12,
  parameter int V_BITS    = 12,
  parameter int MODES     = 4,
  parameter int MODE_BITS = $clog2(MODES),
  parameter int BLANK_CYC = 16
) (
  input  logic           clk,
  input  logic           rst,
  tpg_mode_ctrl_if.slave bus
);

  tpgState_t            state_r, nextState_s;
  logic [MODE_BITS-1:0] selIdx_r, nextSel_s;
  logic                 retRun_r, nextRetRun_s;
  logic                 nextEn_s, reqSeen_s, entryOk_s;
  logic                 tpgEn_r, modeAck_r, modeErr_r;
  logic [MODE_BITS-1:0] curMode_r;
  timingSet_t           timing_r, rdSet_s;

  tpg_mode_table #(.MODES(MODES), .MODE_BITS(MODE_BITS)) u_table (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (bus.cfg_wr),
    .wrIdx  (bus.cfg_idx),
    .wrField(bus.cfg_field),
    .wrData (bus.cfg_data),
    .rdIdx  (selIdx_r),
    .rdSet  (rdSet_s)
  );

  assign entryOk_s = isValidSet(rdSet_s);

`ifdef TPG_MODE_CTRL_BLANK_EN
  localparam int CNT_W = $clog2(BLANK_CYC + 1);
  logic [CNT_W-1:0] blankCnt_r;

  // Countdown of enable-low cycles; loaded as the live switch is acknowledged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blankCnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_LOAD && nextState_s == ST_BLANK) begin
      blankCnt_r <= CNT_W'(BLANK_CYC - 1);
    end else if (state_r == ST_BLANK && blankCnt_r != {CNT_W{1'b0}}) begin
      blankCnt_r <= blankCnt_r - CNT_W'(1);
    end
  end
`endif

  // Next-state, latched request and next enable. The ack cycle never re-arms a request.
  always_comb begin
    nextState_s  = state_r;
    nextSel_s    = selIdx_r;
    nextRetRun_s = retRun_r;
    nextEn_s     = 1'b0;
    reqSeen_s    = bus.mode_req && !modeAck_r;
    case (state_r)
      ST_IDLE: begin
        if (reqSeen_s) begin
          nextState_s  = ST_LOAD;
          nextSel_s    = bus.mode_sel;
          nextRetRun_s = 1'b0;
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.stop_req) begin
          nextState_s = ST_IDLE;
        end else if (reqSeen_s) begin
          nextState_s  = bus.frame_end ? ST_LOAD : ST_WAIT_FE;
          nextSel_s    = bus.mode_sel;
          nextRetRun_s = 1'b1;
        end else begin
          nextState_s = ST_RUN;
        end
      end
      ST_WAIT_FE: begin
        if (bus.stop_req) begin
          nextState_s = ST_IDLE;
        end else if (bus.frame_end) begin
          nextState_s = ST_LOAD;
        end else begin
          nextState_s = ST_WAIT_FE;
        end
      end
      ST_LOAD: begin
        if (entryOk_s) begin
`ifdef TPG_MODE_CTRL_BLANK_EN
          nextState_s = retRun_r ? ST_BLANK : ST_RUN;
`else
          nextState_s = ST_RUN;
`endif
        end else begin
          nextState_s = retRun_r ? ST_RUN : ST_IDLE;
        end
      end
`ifdef TPG_MODE_CTRL_BLANK_EN
      ST_BLANK: begin
        if (blankCnt_r == {CNT_W{1'b0}}) begin
          nextState_s = ST_RUN;
        end else begin
          nextState_s = ST_BLANK;
        end
      end
`endif
      default: nextState_s = ST_IDLE;
    endcase

    // A live switch keeps the generator running through the LOAD cycle.
    case (nextState_s)
      ST_RUN:     nextEn_s = 1'b1;
      ST_WAIT_FE: nextEn_s = 1'b1;
      ST_LOAD:    nextEn_s = nextRetRun_s;
      default:    nextEn_s = 1'b0;
    endcase
  end

  // State register and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      selIdx_r  <= {MODE_BITS{1'b0}};
      retRun_r  <= 1'b0;
      tpgEn_r   <= 1'b0;
      modeAck_r <= 1'b0;
      modeErr_r <= 1'b0;
    end else begin
      state_r   <= nextState_s;
      selIdx_r  <= nextSel_s;
      retRun_r  <= nextRetRun_s;
      tpgEn_r   <= nextEn_s;
      modeAck_r <= (state_r == ST_LOAD);
      modeErr_r <= (state_r == ST_LOAD) && !entryOk_s;
    end
  end

  // Applied timing set; changes only when a valid entry is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timing_r  <= {$bits(timingSet_t){1'b0}};
      curMode_r <= {MODE_BITS{1'b0}};
    end else if (state_r == ST_LOAD && entryOk_s) begin
      timing_r  <= rdSet_s;
      curMode_r <= selIdx_r;
    end
  end

  assign bus.mode_ack    = modeAck_r;
  assign bus.mode_err    = modeErr_r;
  assign bus.tpg_en      = tpgEn_r;
  assign bus.cur_mode    = curMode_r;
  assign bus.tHS_START   = H_BITS'(timing_r.hsStart);
  assign bus.tHS_END     = H_BITS'(timing_r.hsEnd);
  assign bus.tHACT_START = H_BITS'(timing_r.hactStart);
  assign bus.tHACT_END   = H_BITS'(timing_r.hactEnd);
  assign bus.tH_END      = H_BITS'(timing_r.hEnd);
  assign bus.tVS_START   = V_BITS'(timing_r.vsStart);
  assign bus.tVS_END     = V_BITS'(timing_r.vsEnd);
  assign bus.tVACT_START = V_BITS'(timing_r.vactStart);
  assign bus.tVACT_END   = V_BITS'(timing_r.vactEnd);
  assign bus.tV_END      = V_BITS'(timing_r.vEnd);

endmodule

// File: doc/tpg_mode_ctrl.md
# tpg_mode_ctrl

Mode controller for the test pattern generator. It holds a table of video timing modes written over a simple config port. On request it applies the selected mode to the generator's ten timing inputs, and only at a frame boundary while the generator runs. It sits between the host/config bus and the `tpg` instance: it drives the timing buses and the generator enable, and consumes the generator's end-of-frame pulse.

## Interface
Parameters:
- `H_BITS`, 12: width of horizontal timing fields.
- `V_BITS`, 12: width of vertical timing fields.
- `MODES`, 4: number of table entries (power of two).
- `MODE_BITS`, $clog2(MODES): mode index width.
- `BLANK_CYC`, 16: enable-low cycles after a live mode switch; used only with the blanking feature.

Ports:
- `clk`  in  1  single clock; all logic is in this domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `cfg_wr`  in  1  table write strobe.
- `cfg_idx`  in  MODE_BITS  entry written.
- `cfg_field`  in  4  field number 0..9, in this order: HS_START, HS_END, HACT_START, HACT_END, H_END, VS_START, VS_END, VACT_START, VACT_END, V_END.
- `cfg_data`  in  16  value. Truncated to H_BITS for fields 0–4 and to V_BITS for fields 5–9.
- `mode_req`  in  1  request, held until `mode_ack`.
- `mode_sel`  in  MODE_BITS  requested entry, stable while `mode_req` is high.
- `stop_req`  in  1  pulse that disables the generator.
- `frame_end`  in  1  one-cycle pulse from the generator on the last pixel of a frame.
- `mode_ack`  out  1  one-cycle acknowledge.
- `mode_err`  out  1  valid with `mode_ack`; 1 means the request was rejected.
- `tpg_en`  out  1  generator enable.
- `cur_mode`  out  MODE_BITS  last applied entry.
- `tHS_START`…`tV_END`  out  H_BITS/V_BITS  registered timing values to the generator.

## Operation
- The table is a register array MODES×10. It is a shadow store: writing an entry never changes the outputs until that entry is applied.
- Writes with `cfg_field` ≥ 10 are ignored.
- States:
  - IDLE: `tpg_en`=0.
  - RUN: `tpg_en`=1.
  - WAIT_FE: `tpg_en`=1, request latched.
  - LOAD: one cycle.
  - BLANK: only with the blanking feature.
- IDLE + `mode_req` → LOAD. A stopped generator needs no frame boundary.
- RUN + `mode_req` → WAIT_FE. If `frame_end` is high in the same cycle, the transition is RUN → LOAD directly.
- WAIT_FE + `frame_end` → LOAD.
- LOAD:
  - Validates the entry: H_END≠0 and V_END≠0.
  - Valid entry: copies all ten fields to the outputs, sets `cur_mode`, pulses `mode_ack` with `mode_err`=0, then → RUN (or → BLANK).
  - Invalid entry: leaves the outputs untouched, pulses `mode_ack` with `mode_err`=1, then returns to the state held before the request (IDLE or RUN).
- `stop_req` in RUN or WAIT_FE → IDLE with `tpg_en`=0. A pending request in WAIT_FE is then served from IDLE on the next cycle, because `mode_req` is still high.
- `stop_req` is ignored in LOAD and BLANK.
- A `cfg_wr` to the entry being read in the LOAD cycle: LOAD uses the pre-write value.

## Timing
- Reset values:
  - All outputs 0: `tpg_en`, `mode_ack`, `mode_err`, `cur_mode`, and all timing buses.
  - State IDLE.
  - Table cleared to 0.
- From IDLE: `mode_req` sampled at edge k → LOAD. At edge k+1 the outputs update, `tpg_en`=1 and `mode_ack`=1 for one cycle. Latency is 2 cycles.
- From RUN: `frame_end` sampled at edge m while pending → at edge m+1 the outputs update and `mode_ack` pulses. Timing outputs change only in the cycle after a frame boundary.
- `mode_ack` is never high for two consecutive cycles.
- The requester drops `mode_req` in the cycle after `mode_ack`. The controller ignores `mode_req` in the ack cycle.
- Asserting `rst` mid-operation returns everything to reset values immediately. A pending request is dropped without an ack.

## Configuration
- Macro: `TPG_MODE_CTRL_BLANK_EN`.
- Defined:
  - A valid LOAD entered from RUN/WAIT_FE goes to BLANK.
  - BLANK holds `tpg_en`=0 for exactly BLANK_CYC cycles, using a countdown sized $clog2(BLANK_CYC+1), then → RUN.
  - A LOAD entered from IDLE skips BLANK.
- Undefined: the BLANK state and its counter are absent, and `tpg_en` stays 1 across a live switch.

## Structure
- Shared package `tpg_pkg` holds:
  - Field index constants `F_HS_START`..`F_V_END` and `N_FIELDS`=10.
  - The state enum.
  - The timing-set struct, parameterised on H_BITS/V_BITS via localparams.
- One natural sub-module: `tpg_mode_table`, the register array plus its write decode and read mux.

## Test plan
- Reset → all outputs 0, state IDLE. Write entry 1 with H_END=15, V_END=10. Request mode 1 → `mode_ack` 2 cycles later, `mode_err`=0, `tH_END`=15, `tpg_en`=1.
- In RUN, write entry 2 and request mode 2. Outputs hold across 100 cycles. `frame_end` at cycle 100 → outputs update at 101, `cur_mode`=2.
- `mode_req` and `frame_end` in the same RUN cycle → ack 2 cycles later, with no wait for the next frame.
- Request an all-zero entry 3 → `mode_ack` with `mode_err`=1, outputs and `cur_mode` unchanged, state unchanged.
- Assert `stop_req` during WAIT_FE → `tpg_en`=0 next cycle, request served from IDLE, ack with the new mode.
- With `TPG_MODE_CTRL_BLANK_EN` and BLANK_CYC=16: live switch → `tpg_en`=0 for exactly 16 cycles after the ack, then 1. Without the macro, `tpg_en` never drops.
